game_sequencer: RTL and testbench

Top-level game-flow controller for the runner game. It sequences the round through idle, start countdown, play and game-over hold, and generates the game tick that paces the scrolling datapath. It also gates player jumps, keeps the score and high score, and flags a new record. It sits between the input debouncers / collision detector and the scroll, physics and display blocks.

---
 rtl/game_sequencer.sv | 145 ++++++++++++++
 tb/tb_game_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Runner game flow controller: idle/countdown/play/game-over sequencing,
// game tick generation, jump gating, score and high-score tracking.
module game_sequencer #(
  parameter int unsigned TICK_DIV        = 2500000,
  parameter int unsigned COUNTDOWN_TICKS = 120,
  parameter int unsigned HOLD_TICKS      = 80,
  parameter int unsigned SCORE_MAX       = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       jump_op,
  input  logic       dead,
  input  logic       pass,
  output logic [1:0] state,
  output logic       game_tick,
  output logic       run,
  output logic       flap,
  output logic [1:0] cd_digit,
  output logic [9:0] score,
  output logic [9:0] high_score,
  output logic       new_record
);

  localparam int unsigned DIV_W  = $clog2(TICK_DIV);
  localparam int unsigned PH_MAX = (COUNTDOWN_TICKS > HOLD_TICKS) ? COUNTDOWN_TICKS : HOLD_TICKS;
  localparam int unsigned PH_CW  = $clog2(PH_MAX + 1);
  localparam int unsigned PH_W   = (PH_CW < 8) ? 8 : PH_CW;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]  CD_LOAD  = PH_W'(COUNTDOWN_TICKS - 1);
  localparam logic [PH_W-1:0]  HOLD_LOAD = PH_W'(HOLD_TICKS - 1);
  localparam logic [PH_W-1:0]  CD_HI    = PH_W'((2 * COUNTDOWN_TICKS) / 3);
  localparam logic [PH_W-1:0]  CD_LO    = PH_W'(COUNTDOWN_TICKS / 3);
  localparam logic [9:0]       SMAX     = 10'(SCORE_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_COUNT = 2'b10,
    S_OVER  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic             tick_q;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [9:0]       score_q, score_d;
  logic [9:0]       high_q, high_d;
  logic             rec_q, rec_d;
  logic             run_q, run_d;
  logic [1:0]       cd_q, cd_d;

  // Free-running divider; never re-phased on state changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      tick_q <= (div_q == DIV_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      score_q <= '0;
      high_q  <= '0;
      rec_q   <= 1'b0;
      run_q   <= 1'b0;
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      score_q <= score_d;
      high_q  <= high_d;
      rec_q   <= rec_d;
      run_q   <= run_d;
      cd_q    <= cd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    score_d = score_q;
    high_d  = high_q;
    rec_d   = rec_q;
    unique case (state_q)
      S_IDLE: begin
        if (jump_op) begin
          state_d = S_COUNT;
          ph_d    = CD_LOAD;
          score_d = '0;
          rec_d   = 1'b0;
        end
      end
      S_COUNT: begin
        if (tick_q) begin
          if (ph_q == '0) state_d = S_PLAY;
          else            ph_d    = ph_q - 1'b1;
        end
      end
      S_PLAY: begin
        if (dead) begin
          state_d = S_OVER;
          ph_d    = HOLD_LOAD;
          if (score_q > high_q) begin
            high_d = score_q;
            rec_d  = 1'b1;
          end
        end else if (pass && (score_q < SMAX)) begin
          score_d = score_q + 1'b1;
        end
      end
      S_OVER: begin
        if (tick_q) begin
          if (ph_q == '0) state_d = S_IDLE;
          else            ph_d    = ph_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // run and cd_digit are registered from next-state so they track state exactly.
    run_d = (state_d == S_PLAY);
    cd_d  = 2'd0;
    if (state_d == S_COUNT) begin
      if (ph_d >= CD_HI)      cd_d = 2'd3;
      else if (ph_d >= CD_LO) cd_d = 2'd2;
      else                    cd_d = 2'd1;
    end
  end

  assign state      = state_q;
  assign game_tick  = tick_q;
  assign run        = run_q;
  assign flap       = jump_op & (state_q == S_PLAY);
  assign cd_digit   = cd_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign new_record = rec_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed round scenarios followed by random
// stimulus, every cycle compared against a tick-counting reference model.
module tb_game_sequencer;

  localparam int unsigned TD = 4;
  localparam int unsigned CT = 6;
  localparam int unsigned HT = 3;
  localparam int unsigned SM = 5;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_COUNT = 2;
  localparam int M_OVER  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       jump_op = 1'b0;
  logic       dead = 1'b0;
  logic       pass = 1'b0;
  logic [1:0] state;
  logic       game_tick;
  logic       run;
  logic       flap;
  logic [1:0] cd_digit;
  logic [9:0] score;
  logic [9:0] high_score;
  logic       new_record;

  game_sequencer #(
    .TICK_DIV        (TD),
    .COUNTDOWN_TICKS (CT),
    .HOLD_TICKS      (HT),
    .SCORE_MAX       (SM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .jump_op    (jump_op),
    .dead       (dead),
    .pass       (pass),
    .state      (state),
    .game_tick  (game_tick),
    .run        (run),
    .flap       (flap),
    .cd_digit   (cd_digit),
    .score      (score),
    .high_score (high_score),
    .new_record (new_record)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycles since reset, ticks left in the current phase.
  int m_mode  = M_IDLE;
  int m_cyc   = 0;
  int m_left  = 0;
  int m_score = 0;
  int m_hs    = 0;
  int m_nr    = 0;
  int m_tick  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_digit();
    int ph;
    if (m_mode != M_COUNT) return 0;
    ph = m_left - 1;
    if (ph >= (2 * CT) / 3) return 3;
    if (ph >= CT / 3) return 2;
    return 1;
  endfunction

  task automatic model_step(input bit r, input bit j, input bit d, input bit p);
    int tick_now;
    if (r) begin
      m_mode = M_IDLE; m_cyc = 0; m_left = 0;
      m_score = 0; m_hs = 0; m_nr = 0; m_tick = 0;
      return;
    end
    tick_now = m_tick;
    m_cyc++;
    m_tick = (m_cyc % TD == 0) ? 1 : 0;
    case (m_mode)
      M_IDLE: if (j) begin
        m_mode = M_COUNT; m_left = CT; m_score = 0; m_nr = 0;
      end
      M_COUNT: if (tick_now == 1) begin
        m_left--;
        if (m_left == 0) m_mode = M_PLAY;
      end
      M_PLAY: begin
        if (d) begin
          m_mode = M_OVER; m_left = HT;
          if (m_score > m_hs) begin m_hs = m_score; m_nr = 1; end
        end else if (p) begin
          m_score = (m_score + 1 > SM) ? SM : m_score + 1;
        end
      end
      default: if (tick_now == 1) begin
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
    endcase
  endtask

  task automatic drive(input bit r, input bit j, input bit d, input bit p);
    @(negedge clk);
    rst = r; jump_op = j; dead = d; pass = p;
    model_step(r, j, d, p);
    @(posedge clk);
    #1;
    check_eq("state", state, m_mode);
    check_eq("game_tick", game_tick, m_tick);
    check_eq("run", run, (m_mode == M_PLAY) ? 1 : 0);
    check_eq("flap", flap, (j && m_mode == M_PLAY) ? 1 : 0);
    check_eq("cd_digit", cd_digit, exp_digit());
    check_eq("score", score, m_score);
    check_eq("high_score", high_score, m_hs);
    check_eq("new_record", new_record, m_nr);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] target, input int budget);
    int n = 0;
    while (state !== target && n < budget) begin
      drive(0, 0, 0, 0);
      n++;
    end
    check_eq(tag, state, target);
  endtask

  task automatic check_reset_values();
    check_eq("rst_state", state, 0);
    check_eq("rst_tick", game_tick, 0);
    check_eq("rst_run", run, 0);
    check_eq("rst_flap", flap, 0);
    check_eq("rst_cd", cd_digit, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_hs", high_score, 0);
    check_eq("rst_nr", new_record, 0);
  endtask

  task automatic passes(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    check_reset_values();
    repeat (20) drive(0, 0, 0, 0);
    check_eq("idle_state", state, 2'b00);

    // Round 1: countdown, flap gating, score 3 then dead with pass.
    drive(0, 1, 0, 0);
    check_eq("count_entry", state, 2'b10);
    check_eq("count_digit0", cd_digit, 3);
    drive(0, 1, 0, 0);
    check_eq("count_no_flap", flap, 0);
    wait_state("reach_play1", 2'b01, 40);
    check_eq("play_run", run, 1);
    drive(0, 1, 0, 0);
    check_eq("play_flap", flap, 1);
    passes(3);
    drive(0, 0, 1, 1);
    check_eq("over_state", state, 2'b11);
    check_eq("over_score", score, 3);
    check_eq("over_hs", high_score, 3);
    check_eq("over_nr", new_record, 1);
    for (int i = 0; i < 30 && state == 2'b11; i++) drive(0, 1, 0, 0);
    check_eq("over_to_idle", state, 2'b00);
    drive(0, 0, 1, 0);
    check_eq("idle_dead_ignored", state, 2'b00);

    // Round 2: lower score keeps the record.
    drive(0, 1, 0, 0);
    wait_state("reach_play2", 2'b01, 40);
    passes(2);
    drive(0, 0, 1, 0);
    check_eq("r2_score", score, 2);
    check_eq("r2_hs", high_score, 3);
    check_eq("r2_nr", new_record, 0);
    drive(0, 1, 0, 0);
    check_eq("r2_over_jump", state, 2'b11);
    wait_state("r2_idle", 2'b00, 30);

    // Round 3: saturation at SCORE_MAX and new record.
    drive(0, 1, 0, 0);
    wait_state("reach_play3", 2'b01, 40);
    passes(7);
    check_eq("sat_score", score, SM);
    drive(0, 0, 1, 0);
    check_eq("r3_hs", high_score, SM);
    check_eq("r3_nr", new_record, 1);
    wait_state("r3_idle", 2'b00, 30);

    // Reset mid-countdown and mid-play.
    drive(0, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    check_reset_values();
    drive(0, 1, 0, 0);
    wait_state("reach_play4", 2'b01, 40);
    passes(2);
    drive(1, 1, 0, 0);
    check_reset_values();

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      bit r, j, d, p;
      r = ($urandom_range(0, 499) == 0);
      j = ($urandom_range(0, 9) == 0);
      d = (m_mode == M_PLAY) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 2) == 0);
      drive(r, j, d, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
